pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Pipeline sequencing controller for the 5-stage MIPS core. It drives the PC advance enable (`pc_stall`, 1 = PC += 4), the PC redirect select, and the IF/ID, ID/EX and EX/MEM register enables and flushes. Its sources are load-use hazards, data-memory wait states and taken branches. A boot state holds the first fetch at 0x80000000 after reset, and two saturating counters record stall and flush cycles for performance counting.

## Interface
- `WAIT_TIMEOUT`, default 255: MEM_WAIT cycles before `mem_timeout` sets (1..2^16-1).
- `CNT_W`, default 16: width of the performance counters.

- `clk`  in  1  core clock; all state updates on its rising edge.
- `reset`  in  1  reset, asynchronous, active-low.
- `id_rs`  in  5  rs field of the instruction in ID.
- `id_rt`  in  5  rt field of the instruction in ID.
- `id_uses_rt`  in  1  instruction in ID reads rt as a source.
- `ex_memread`  in  1  instruction in EX is a load.
- `ex_rt`  in  5  destination register of the load in EX.
- `ex_branch_taken`  in  1  branch or jump in EX resolved taken.
- `mem_req`  in  1  MEM stage is issuing a data-memory access.
- `mem_ready`  in  1  data memory completes the access this cycle.
- `clr_counters`  in  1  synchronous clear of both counters.
- `pc_stall`  out  1  1 = PC advances by 4 this cycle.
- `pc_redirect`  out  1  1 = PC loads the branch target.
- `ifid_en`, `idex_en`, `exmem_en`  out  1 each  pipeline register write enables.
- `ifid_flush`, `idex_flush`  out  1 each  load a bubble (NOP) into IF/ID or ID/EX.
- `state`  out  2  FSM state: BOOT=0, RUN=1, MEM_WAIT=2.
- `stall_cnt`  out  CNT_W  count of stall cycles.
- `flush_cnt`  out  CNT_W  count of redirect cycles.
- `mem_timeout`  out  1  sticky memory-timeout error.

## Operation
- Load-use hazard: `lu = ex_memread & (ex_rt != 0) & (ex_rt == id_rs | (id_uses_rt & ex_rt == id_rt))`.
- Memory wait: `mw = mem_req & ~mem_ready`.
- All outputs are decoded combinationally from state and inputs (Mealy).
- Default in RUN with no event: `pc_stall`, `ifid_en`, `idex_en` and `exmem_en` are 1; every flush and `pc_redirect` is 0.

Priority in RUN, highest first:
1. `mw`: freeze. `pc_stall`, all enables and all flushes are 0. Next state is MEM_WAIT.
2. `ex_branch_taken`:
   - `pc_redirect`=1, `pc_stall`=0.
   - `ifid_flush`=1, `idex_flush`=1; all enables are 1.
   - `flush_cnt`+1.
   - A simultaneous `lu` is ignored, because the ID instruction is flushed.
3. `lu`:
   - `pc_stall`=0, `ifid_en`=0.
   - `idex_flush`=1, `exmem_en`=1.
   - `stall_cnt`+1.

State behaviour:
- BOOT:
  - Entered on reset and lasts exactly one cycle after reset release.
  - `pc_stall`=0, `ifid_flush`=1, all enables 0.
  - Next state is RUN.
- MEM_WAIT:
  - While `mem_ready`=0: freeze as in RUN rule 1, and `stall_cnt`+1 per cycle.
  - When `mem_ready`=1: RUN outputs apply this cycle (including branch/lu evaluation, since ID/EX was held stable). Next state is RUN.
- State 3 is unreachable; if entered, next state is BOOT.

Timeout and counters:
- A wait counter (16-bit) clears on MEM_WAIT entry and increments per MEM_WAIT cycle.
- When it reaches `WAIT_TIMEOUT`, `mem_timeout` sets. It clears only on reset.
- The timeout does not change FSM behaviour.
- Both counters saturate at all-ones.
- `clr_counters` zeroes both counters on the next edge and takes priority over a same-cycle increment.

## Timing
Reset values (`reset`=0), applied immediately and asynchronously:
- `state`=BOOT.
- Counters, wait counter and `mem_timeout` are 0.
- Outputs equal BOOT decoding: `pc_stall`=0, `ifid_flush`=1, all else 0.

Reset asserted mid-MEM_WAIT or mid-stall aborts immediately; nothing is retained.

Latency:
- Hazard-to-output latency is 0 cycles (same-cycle combinational).
- Counter and state updates take effect on the following edge.
- A load-use hazard costs exactly one bubble, because the next cycle the load is in MEM and `lu` falls.
- A memory wait of N cycles with `mem_ready`=0 freezes for exactly N cycles.

## Test plan
- Reset: drive `reset`=0 during MEM_WAIT → `state`=0, `pc_stall`=0 at once. Release `reset` → one BOOT cycle (`pc_stall`=0, `ifid_flush`=1), then `state`=1, `pc_stall`=1.
- Load-use: `ex_memread`=1, `ex_rt`=8, `id_rs`=8 for one cycle → `pc_stall`=0, `ifid_en`=0, `idex_flush`=1, `stall_cnt` 0→1. Next cycle with `ex_memread`=0 → `pc_stall`=1.
- No false stall: `ex_rt`=0, `id_rs`=0 → no stall. `ex_rt`=9, `id_rt`=9, `id_uses_rt`=0 → no stall.
- Memory wait: `mem_req`=1 with `mem_ready`=0 for 3 cycles, then 1 → all enables 0 for 3 cycles, `stall_cnt`=3, enables 1 on the ready cycle, `state` back to 1.
- Redirect plus load-use in the same cycle → `pc_redirect`=1, `ifid_flush`=`idex_flush`=1, `flush_cnt`=1, `stall_cnt` unchanged.
- Timeout: `WAIT_TIMEOUT`=4, `mem_ready` held 0 → `mem_timeout` rises after the 4th MEM_WAIT cycle and stays 1 after `mem_ready`=1. `clr_counters` → both counters 0 next cycle.

Source files
------------

// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline datapath and its sequencing controller.
// The controller side takes the slave modport; the datapath (or bench) takes master.
interface pipe_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rt;
    logic             ex_memread;
    logic [4:0]       ex_rt;
    logic             ex_branch_taken;
    logic             mem_req;
    logic             mem_ready;
    logic             clr_counters;

    logic             pc_stall;
    logic             pc_redirect;
    logic             ifid_en;
    logic             idex_en;
    logic             exmem_en;
    logic             ifid_flush;
    logic             idex_flush;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic             mem_timeout;

    modport master (
        output id_rs, id_rt, id_uses_rt, ex_memread, ex_rt, ex_branch_taken,
               mem_req, mem_ready, clr_counters,
        input  pc_stall, pc_redirect, ifid_en, idex_en, exmem_en, ifid_flush,
               idex_flush, state, stall_cnt, flush_cnt, mem_timeout
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, ex_memread, ex_rt, ex_branch_taken,
               mem_req, mem_ready, clr_counters,
        output pc_stall, pc_redirect, ifid_en, idex_en, exmem_en, ifid_flush,
               idex_flush, state, stall_cnt, flush_cnt, mem_timeout
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Sequencing controller for the 5-stage pipeline: hazard stalls, memory-wait
// freezes, branch redirects, boot fetch hold and saturating perf counters.
//
// state     | meaning
// ----------|-------------------------------------------------------------
// BOOT      | one cycle after reset: hold first fetch, bubble into IF/ID
// RUN       | normal issue; load-use and branch handling
// MEM_WAIT  | data memory busy: freeze until mem_ready
// BAD (3)   | unreachable; recovers through BOOT
module pipe_ctrl #(
    parameter int unsigned WAIT_TIMEOUT = 255,
    parameter int          CNT_W        = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    pipe_ctrl_if.slave  pc_if
);
    typedef enum logic [1:0] {
        ST_BOOT     = 2'd0,
        ST_RUN      = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_BAD      = 2'd3
    } state_e;

    localparam logic [15:0] WAIT_LIMIT = WAIT_TIMEOUT[15:0];

    state_e           state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [15:0]      wait_cnt_q, wait_cnt_d;
    logic             timeout_q, timeout_d;

    logic lu, mw, run_dec, stall_inc, flush_inc;
    logic pc_stall, pc_redirect, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush;

    assign lu = pc_if.ex_memread && (pc_if.ex_rt != 5'd0) &&
                ((pc_if.ex_rt == pc_if.id_rs) ||
                 (pc_if.id_uses_rt && (pc_if.ex_rt == pc_if.id_rt)));
    assign mw = pc_if.mem_req && !pc_if.mem_ready;

    always_comb begin
        state_d     = state_q;
        run_dec     = 1'b0;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;
        pc_stall    = 1'b0;
        pc_redirect = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;

        case (state_q)
            ST_BOOT: begin
                ifid_flush = 1'b1;
                state_d    = ST_RUN;
            end
            ST_RUN: begin
                if (mw) begin
                    stall_inc = 1'b1;
                    state_d   = ST_MEM_WAIT;
                end else begin
                    run_dec = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                // ID/EX was held, so the ready cycle re-evaluates branch and load-use
                if (!pc_if.mem_ready) begin
                    stall_inc = 1'b1;
                end else begin
                    run_dec = 1'b1;
                    state_d = ST_RUN;
                end
            end
            default: begin
                ifid_flush = 1'b1;
                state_d    = ST_BOOT;
            end
        endcase

        if (run_dec) begin
            pc_stall = 1'b1;
            ifid_en  = 1'b1;
            idex_en  = 1'b1;
            exmem_en = 1'b1;
            if (pc_if.ex_branch_taken) begin
                pc_stall    = 1'b0;
                pc_redirect = 1'b1;
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                flush_inc   = 1'b1;
            end else if (lu) begin
                pc_stall   = 1'b0;
                ifid_en    = 1'b0;
                idex_flush = 1'b1;
                stall_inc  = 1'b1;
            end
        end
    end

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;
        if (state_q == ST_RUN && mw) begin
            wait_cnt_d = 16'd0;
        end else if (state_q == ST_MEM_WAIT) begin
            if (wait_cnt_q != 16'hFFFF) wait_cnt_d = wait_cnt_q + 16'd1;
            if (wait_cnt_d >= WAIT_LIMIT) timeout_d = 1'b1;
        end

        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (pc_if.clr_counters) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (stall_inc && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
            if (flush_inc && flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_BOOT;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            wait_cnt_q  <= 16'd0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    assign pc_if.pc_stall    = pc_stall;
    assign pc_if.pc_redirect = pc_redirect;
    assign pc_if.ifid_en     = ifid_en;
    assign pc_if.idex_en     = idex_en;
    assign pc_if.exmem_en    = exmem_en;
    assign pc_if.ifid_flush  = ifid_flush;
    assign pc_if.idex_flush  = idex_flush;
    assign pc_if.state       = state_q;
    assign pc_if.stall_cnt   = stall_cnt_q;
    assign pc_if.flush_cnt   = flush_cnt_q;
    assign pc_if.mem_timeout = timeout_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed vector table, hand-written corner sequences and
// a random run checked against a cycle-level behavioural model.
module tb_pipe_ctrl;
    localparam int CW  = 4;
    localparam int WT  = 4;
    localparam int SAT = (1 << CW) - 1;

    // {pc_stall, pc_redirect, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush}
    localparam logic [6:0] C_BOOT = 7'b0000010;
    localparam logic [6:0] C_IDLE = 7'b1011100;
    localparam logic [6:0] C_FRZ  = 7'b0000000;
    localparam logic [6:0] C_BR   = 7'b0111111;
    localparam logic [6:0] C_LU   = 7'b0001101;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipe_ctrl_if #(.CNT_W(CW)) pif ();
    pipe_ctrl #(.WAIT_TIMEOUT(WT), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .pc_if (pif.slave)
    );

    int n_chk  = 0;
    int n_pass = 0;

    int m_mode, m_stall, m_flush, m_wait;
    bit m_to;

    typedef struct {
        logic [4:0] rs, rt;
        logic       uses, mrd;
        logic [4:0] ert;
        logic       br, mreq, mrdy, clr;
        logic [6:0] ctrl;
        int         st, stl, fl;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    function automatic logic [6:0] ctrl_now();
        return {pif.pc_stall, pif.pc_redirect, pif.ifid_en, pif.idex_en,
                pif.exmem_en, pif.ifid_flush, pif.idex_flush};
    endfunction

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                         input logic mrd, input logic [4:0] ert, input logic br,
                         input logic mreq, input logic mrdy, input logic clr);
        pif.id_rs = rs;  pif.id_rt = rt;  pif.id_uses_rt = uses;
        pif.ex_memread = mrd;  pif.ex_rt = ert;  pif.ex_branch_taken = br;
        pif.mem_req = mreq;  pif.mem_ready = mrdy;  pif.clr_counters = clr;
    endtask

    function automatic bit model_lu();
        return pif.ex_memread && pif.ex_rt != 0 &&
               (pif.ex_rt == pif.id_rs || (pif.id_uses_rt && pif.ex_rt == pif.id_rt));
    endfunction

    function automatic logic [6:0] model_ctrl();
        bit mw;
        mw = pif.mem_req && !pif.mem_ready;
        if (m_mode == 0) return C_BOOT;
        if (m_mode == 1 && mw) return C_FRZ;
        if (m_mode == 2 && !pif.mem_ready) return C_FRZ;
        if (pif.ex_branch_taken) return C_BR;
        if (model_lu()) return C_LU;
        return C_IDLE;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_stall = 0; m_flush = 0; m_wait = 0; m_to = 0;
    endtask

    task automatic model_step();
        bit mw, frz, act;
        int nmode;
        mw = pif.mem_req && !pif.mem_ready;
        frz = 0; act = 0; nmode = m_mode;
        case (m_mode)
            0: nmode = 1;
            1: if (mw) begin frz = 1; nmode = 2; end else act = 1;
            default: if (!pif.mem_ready) frz = 1; else begin act = 1; nmode = 1; end
        endcase
        if (m_mode == 1 && mw) m_wait = 0;
        else if (m_mode == 2) begin
            if (m_wait < 65535) m_wait++;
            if (m_wait >= WT) m_to = 1;
        end
        if (pif.clr_counters) begin
            m_stall = 0; m_flush = 0;
        end else begin
            if ((frz || (act && !pif.ex_branch_taken && model_lu())) && m_stall < SAT) m_stall++;
            if (act && pif.ex_branch_taken && m_flush < SAT) m_flush++;
        end
        m_mode = nmode;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".ctrl"},    32'(ctrl_now()),      32'(model_ctrl()));
        chk({tag, ".state"},   32'(pif.state),       32'(m_mode));
        chk({tag, ".stall"},   32'(pif.stall_cnt),   32'(m_stall));
        chk({tag, ".flush"},   32'(pif.flush_cnt),   32'(m_flush));
        chk({tag, ".timeout"}, 32'(pif.mem_timeout), 32'(m_to));
    endtask

    function automatic vec_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                                input logic mrd, input logic [4:0] ert, input logic br,
                                input logic mreq, input logic mrdy, input logic clr,
                                input logic [6:0] ctrl, input int st, input int stl, input int fl);
        vec_t v;
        v.rs = rs; v.rt = rt; v.uses = uses; v.mrd = mrd; v.ert = ert; v.br = br;
        v.mreq = mreq; v.mrdy = mrdy; v.clr = clr; v.ctrl = ctrl;
        v.st = st; v.stl = stl; v.fl = fl;
        return v;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [4:0] pick_reg();
        logic [4:0] r;
        case ($urandom_range(0, 3))
            0: r = 5'd0;
            1: r = 5'd8;
            2: r = 5'd9;
            default: r = 5'($urandom_range(0, 31));
        endcase
        return r;
    endfunction

    vec_t tbl[15];

    initial begin
        tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, C_BOOT, 0, 0, 0);
        tbl[1]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, C_IDLE, 1, 0, 0);
        tbl[2]  = mk(8, 0, 0, 1, 8, 0, 0, 1, 0, C_LU,   1, 0, 0);
        tbl[3]  = mk(8, 0, 0, 0, 8, 0, 0, 1, 0, C_IDLE, 1, 1, 0);
        tbl[4]  = mk(0, 0, 0, 1, 0, 0, 0, 1, 0, C_IDLE, 1, 1, 0);
        tbl[5]  = mk(3, 9, 0, 1, 9, 0, 0, 1, 0, C_IDLE, 1, 1, 0);
        tbl[6]  = mk(3, 9, 1, 1, 9, 0, 0, 1, 0, C_LU,   1, 1, 0);
        tbl[7]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, C_FRZ,  1, 2, 0);
        tbl[8]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, C_FRZ,  2, 3, 0);
        tbl[9]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, C_FRZ,  2, 4, 0);
        tbl[10] = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, C_IDLE, 2, 5, 0);
        tbl[11] = mk(8, 0, 0, 1, 8, 1, 0, 1, 0, C_BR,   1, 5, 0);
        tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, C_IDLE, 1, 5, 1);
        tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, C_IDLE, 1, 5, 1);
        tbl[14] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, C_IDLE, 1, 0, 0);

        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        model_reset();
        #3;
        chk("reset.ctrl",  32'(ctrl_now()),    32'(C_BOOT));
        chk("reset.state", 32'(pif.state),     32'd0);
        chk("reset.stall", 32'(pif.stall_cnt), 32'd0);
        chk("reset.to",    32'(pif.mem_timeout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // directed table, starting on the BOOT cycle
        for (int i = 0; i < 15; i++) begin
            if (i > 0) @(negedge clk);
            drive(tbl[i].rs, tbl[i].rt, tbl[i].uses, tbl[i].mrd, tbl[i].ert, tbl[i].br,
                  tbl[i].mreq, tbl[i].mrdy, tbl[i].clr);
            #1;
            chk($sformatf("tbl%0d.ctrl", i),  32'(ctrl_now()),    32'(tbl[i].ctrl));
            chk($sformatf("tbl%0d.state", i), 32'(pif.state),     32'(tbl[i].st));
            chk($sformatf("tbl%0d.stall", i), 32'(pif.stall_cnt), 32'(tbl[i].stl));
            chk($sformatf("tbl%0d.flush", i), 32'(pif.flush_cnt), 32'(tbl[i].fl));
            model_step();
        end

        // reset asserted mid MEM_WAIT aborts at once
        @(negedge clk); drive(0, 0, 0, 0, 0, 0, 1, 0, 0); #1; model_step();
        @(negedge clk); #1;
        chk("rstwait.state_before", 32'(pif.state), 32'd2);
        #1 rst_n = 1'b0;
        #1;
        chk("rstwait.state", 32'(pif.state),      32'd0);
        chk("rstwait.ctrl",  32'(ctrl_now()),     32'(C_BOOT));
        chk("rstwait.stall", 32'(pif.stall_cnt),  32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        #1;
        chk("boot.ctrl",  32'(ctrl_now()), 32'(C_BOOT));
        chk("boot.state", 32'(pif.state),  32'd0);
        model_step();
        @(negedge clk); #1;
        chk("postboot.state", 32'(pif.state),    32'd1);
        chk("postboot.pcst",  32'(pif.pc_stall), 32'd1);
        model_step();

        // timeout after the WT-th MEM_WAIT cycle, sticky afterwards
        @(negedge clk); drive(0, 0, 0, 0, 0, 0, 1, 0, 0); #1; check_model("to.enter"); model_step();
        for (int k = 1; k <= WT + 1; k++) begin
            @(negedge clk); #1;
            chk($sformatf("to.wait%0d", k), 32'(pif.mem_timeout), 32'(k > WT));
            check_model("to.seq");
            model_step();
        end
        @(negedge clk); pif.mem_ready = 1'b1; #1;
        chk("to.ready", 32'(pif.mem_timeout), 32'd1);
        model_step();
        @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0, 1, 1); #1;
        chk("to.afterrdy", 32'(pif.mem_timeout), 32'd1);
        model_step();
        @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0, 1, 0); #1;
        chk("clr.stall", 32'(pif.stall_cnt),   32'd0);
        chk("clr.flush", 32'(pif.flush_cnt),   32'd0);
        chk("clr.to",    32'(pif.mem_timeout), 32'd1);
        model_step();

        // saturation of both counters
        for (int k = 0; k < SAT + 5; k++) begin
            @(negedge clk); drive(8, 0, 0, 1, 8, 0, 0, 1, 0); #1; model_step();
        end
        for (int k = 0; k < SAT + 5; k++) begin
            @(negedge clk); drive(0, 0, 0, 0, 0, 1, 0, 1, 0); #1; model_step();
        end
        @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0, 1, 0); #1;
        chk("sat.stall", 32'(pif.stall_cnt), 32'(SAT));
        chk("sat.flush", 32'(pif.flush_cnt), 32'(SAT));
        model_step();

        // random run against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (c > 0) @(negedge clk);
            drive(pick_reg(), pick_reg(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  pick_reg(), ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 60) == 0));
            #1;
            check_model("rnd");
            model_step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
